rca_result_collector: RTL and testbench



---
 rtl/rca_result_collector.sv | 141 ++++++++++++++
 tb/tb_rca_result_collector.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rca_result_collector.sv
// rca_result_collector
//   Return path for the reconfigurable custom accelerators. Each cycle a
//   round-robin arbiter accepts at most one result from the NUM_RCAS result
//   ports. Accepted results go into an in-order FIFO. The FIFO head is
//   presented to writeback as a done/ack/rd/id unit interface.
//
// Ports
//   clk, rst     core clock, synchronous active-high reset
//   rca_valid    per-RCA result valid
//   rca_ready    per-RCA grant (one-hot or zero), combinational
//   rca_result   packed results, slice i = RCA i
//   rca_id       packed instruction ids, slice i = RCA i
//   wb_done      head entry available
//   wb_rd/wb_id  head data/id, zero when empty
//   wb_ack       writeback consumes head (ignored when wb_done = 0)
//   occupancy    number of queued entries
module rca_result_collector #(
  parameter int NUM_RCAS   = 3,
  parameter int XLEN       = 32,
  parameter int ID_W       = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RCAS-1:0]      rca_valid,
  output logic [NUM_RCAS-1:0]      rca_ready,
  input  logic [NUM_RCAS*XLEN-1:0] rca_result,
  input  logic [NUM_RCAS*ID_W-1:0] rca_id,
  output logic                     wb_done,
  output logic [XLEN-1:0]          wb_rd,
  output logic [ID_W-1:0]          wb_id,
  input  logic                     wb_ack,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int RRW = (NUM_RCAS > 1) ? $clog2(NUM_RCAS) : 1;

  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [RRW-1:0]  rr_q, rr_d;

  logic [XLEN-1:0] data_q [FIFO_DEPTH];
  logic [ID_W-1:0] idq_q  [FIFO_DEPTH];

  logic                  found;
  logic [RRW-1:0]        gnt_idx;
  logic                  can_push, push, pop;
  logic [XLEN-1:0]       wdata;
  logic [ID_W-1:0]       wid;

  // Rotate valids so bit 0 is the RR pointer position, take the lowest set
  // bit, then map the offset back to an absolute RCA index.
  logic [2*NUM_RCAS-1:0] vv;
  logic [NUM_RCAS-1:0]   rot;
  logic [RRW-1:0]        off;
  logic [RRW:0]          sum;

  always_comb begin
    vv    = {rca_valid, rca_valid};
    rot   = NUM_RCAS'(vv >> rr_q);
    found = 1'b0;
    off   = '0;
    for (int k = NUM_RCAS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = RRW'(k);
      end
    end
    sum = {1'b0, rr_q} + {1'b0, off};
    if (sum >= (RRW+1)'(NUM_RCAS)) sum = sum - (RRW+1)'(NUM_RCAS);
    gnt_idx = sum[RRW-1:0];
  end

  assign wb_done  = (count_q != '0);
  assign pop      = wb_done & wb_ack;
  // A full FIFO that pops this cycle still has room for the new entry.
  assign can_push = (count_q < CW'(FIFO_DEPTH)) | pop;
  assign push     = found & can_push & ~rst;

  always_comb begin
    rca_ready = '0;
    if (push) rca_ready = NUM_RCAS'(1) << gnt_idx;
  end

  always_comb begin
    wdata = '0;
    wid   = '0;
    for (int k = 0; k < NUM_RCAS; k++) begin
      if (gnt_idx == RRW'(k)) begin
        wdata = rca_result[k*XLEN +: XLEN];
        wid   = rca_id[k*ID_W +: ID_W];
      end
    end
  end

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    rr_d    = rr_q;
    count_d = count_q;
    if (push) begin
      wr_d = wr_q + 1'b1;
      rr_d = (gnt_idx == RRW'(NUM_RCAS - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      rr_q    <= '0;
    end else begin
      count_q <= count_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      rr_q    <= rr_d;
    end
  end

  // Storage needs no reset: the outputs are masked whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_q] <= wdata;
      idq_q[wr_q]  <= wid;
    end
  end

  assign wb_rd     = wb_done ? data_q[rd_q] : '0;
  assign wb_id     = wb_done ? idq_q[rd_q]  : '0;
  assign occupancy = count_q;

endmodule

// File: tb/tb_rca_result_collector.sv
module tb_rca_result_collector;
  localparam int N  = 3;
  localparam int XL = 32;
  localparam int IW = 3;
  localparam int D  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rca_valid;
  logic [N-1:0]    rca_ready;
  logic [N*XL-1:0] rca_result;
  logic [N*IW-1:0] rca_id;
  logic            wb_done;
  logic [XL-1:0]   wb_rd;
  logic [IW-1:0]   wb_id;
  logic            wb_ack;
  logic [2:0]      occupancy;

  int n_chk = 0;
  int n_err = 0;

  rca_result_collector #(.NUM_RCAS(N), .XLEN(XL), .ID_W(IW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .rca_valid(rca_valid), .rca_ready(rca_ready),
    .rca_result(rca_result), .rca_id(rca_id), .wb_done(wb_done),
    .wb_rd(wb_rd), .wb_id(wb_id), .wb_ack(wb_ack), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are checked in the low phase; each step
  // advances exactly one rising edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_rca(input int i, input logic [XL-1:0] r, input logic [IW-1:0] id);
    rca_result[i*XL +: XL] = r;
    rca_id[i*IW +: IW]     = id;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rca_valid = '0; rca_result = '0; rca_id = '0; wb_ack = 1'b0;
    step();

    // reset: grants suppressed even with all valid
    rca_valid = 3'b111;
    #1 chk("rst_ready", rca_ready, 0);
    step();
    rst = 1'b0; rca_valid = '0;
    #1;
    chk("rst_done", wb_done, 0);
    chk("rst_rd", wb_rd, 0);
    chk("rst_id", wb_id, 0);
    chk("rst_occ", occupancy, 0);

    // single result from RCA 1
    set_rca(1, 32'hDEADBEEF, 3'd5);
    rca_valid = 3'b010;
    #1 chk("single_ready", rca_ready, 3'b010);
    step();
    rca_valid = '0;
    #1;
    chk("single_done", wb_done, 1);
    chk("single_rd", wb_rd, 32'hDEADBEEF);
    chk("single_id", wb_id, 5);
    chk("single_occ", occupancy, 1);
    wb_ack = 1'b1;
    step();
    wb_ack = 1'b0;
    #1;
    chk("single_pop_done", wb_done, 0);
    chk("single_pop_rd", wb_rd, 0);

    // round-robin with continuous ack
    do_reset();
    for (int i = 0; i < N; i++) set_rca(i, 32'h1000 + i, IW'(i + 1));
    rca_valid = 3'b111; wb_ack = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("rr_gnt%0d", k), rca_ready, 3'b001 << (k % 3));
      if (k > 0) chk($sformatf("rr_id%0d", k), wb_id, ((k - 1) % 3) + 1);
      step();
    end
    rca_valid = '0;
    #1;
    chk("rr_last_done", wb_done, 1);
    chk("rr_last_id", wb_id, 2);
    step();
    wb_ack = 1'b0;
    #1 chk("rr_drained", occupancy, 0);

    // full backpressure from RCA 0
    do_reset();
    rca_valid = 3'b001;
    for (int j = 1; j <= 4; j++) begin
      set_rca(0, 32'hA000_0000 | j, IW'(j));
      #1 chk($sformatf("bp_acc%0d", j), rca_ready, 3'b001);
      step();
    end
    set_rca(0, 32'hA000_0005, 3'd5);
    #1;
    chk("bp_full_ready", rca_ready, 0);
    chk("bp_full_occ", occupancy, 4);
    step();
    #1;
    chk("bp_hold_ready", rca_ready, 0);
    chk("bp_hold_head", wb_id, 1);
    wb_ack = 1'b1;
    #1 chk("bp_pushpop_ready", rca_ready, 3'b001);
    step();
    wb_ack = 1'b0; rca_valid = '0;
    #1;
    chk("bp_pushpop_occ", occupancy, 4);
    chk("bp_pushpop_head", wb_id, 2);
    wb_ack = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      #1;
      chk($sformatf("bp_drain_id%0d", j), wb_id, j);
      chk($sformatf("bp_drain_rd%0d", j), wb_rd, 32'hA000_0000 | j);
      step();
    end
    wb_ack = 1'b0;
    #1 chk("bp_empty", occupancy, 0);

    // wrap-around: 10 single push/pop pairs
    for (int j = 0; j < 10; j++) begin
      set_rca(0, 32'h5500 + j, IW'(j % 8));
      rca_valid = 3'b001;
      #1 chk($sformatf("wrap_ready%0d", j), rca_ready, 3'b001);
      step();
      rca_valid = '0; wb_ack = 1'b1;
      #1;
      chk($sformatf("wrap_id%0d", j), wb_id, j % 8);
      chk($sformatf("wrap_rd%0d", j), wb_rd, 32'h5500 + j);
      step();
      wb_ack = 1'b0;
    end
    #1 chk("wrap_empty", wb_done, 0);

    // reset mid-operation with three queued entries
    rca_valid = 3'b001;
    for (int j = 0; j < 3; j++) begin
      set_rca(0, 32'h77 + j, IW'(j));
      step();
    end
    rca_valid = '0;
    #1 chk("mid_occ3", occupancy, 3);
    rst = 1'b1;
    set_rca(2, 32'h2222, 3'd7);
    rca_valid = 3'b100;
    #1 chk("mid_rst_ready", rca_ready, 0);
    step();
    rst = 1'b0;
    set_rca(0, 32'h0C0C, 3'd6);
    rca_valid = 3'b101;
    #1;
    chk("mid_done", wb_done, 0);
    chk("mid_occ", occupancy, 0);
    chk("mid_prio", rca_ready, 3'b001);
    step();
    rca_valid = '0;
    #1;
    chk("mid_head", wb_id, 6);
    wb_ack = 1'b1;
    step();

    // spurious ack on an empty FIFO
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("spur_occ%0d", k), occupancy, 0);
      chk($sformatf("spur_done%0d", k), wb_done, 0);
      step();
    end
    wb_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
